// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - retire-strobe execution trace recorder with PC trigger and oldest-first readout
// Optional feature macro: TRACE_TIMESTAMP_EN (appends a 16-bit cycle stamp as rd_data[15:0])
module trace_buffer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int POST_TRIG = 16,
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = 60
`else
  localparam int DW = 44
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [15:0]       trig_pc,
  input  logic              ret_valid,
  input  logic [15:0]       ret_pc,
  input  logic [7:0]        ret_ir,
  input  logic [15:0]       ret_sp,
  input  logic [3:0]        ret_flags,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              triggered
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} st_t;

  localparam logic [ADDR_W:0]   FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_N = ADDR_W'(POST_TRIG);

  st_t               st;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] post_cnt;
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     mem_q;
  logic              rd_zero;
  logic [DW-1:0]     entry;

  // arm is ignored only while finishing the post-trigger window
  logic restart;
  logic hit;
  logic we;
  logic rd_go;
  logic rd_oob;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] port_addr;

  assign restart   = arm && (st != POST);
  assign hit       = ret_valid && trig_en && (ret_pc == trig_pc);
  assign we        = ret_valid && !restart && ((st == ARMED) || (st == POST));
  assign rd_go     = rd_req && (st == DONE);
  assign raddr     = wr_ptr - count[ADDR_W-1:0] + rd_idx;
  assign rd_oob    = {1'b0, rd_idx} >= count;
  // writes and reads never overlap (reads only in DONE), so one address port suffices
  assign port_addr = (st == DONE) ? raddr : wr_ptr;
  assign state     = st;
  assign rd_data   = (rd_valid && !rd_zero) ? mem_q : '0;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  // free-running cycle stamp, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= 16'd0;
    else      ts <= ts + 16'd1;
  end

  assign entry = {ret_pc, ret_ir, ret_sp, ret_flags, ts};
`else
  assign entry = {ret_pc, ret_ir, ret_sp, ret_flags};
`endif

  // capture control: arm/restart, write pointer, fill count, trigger and post window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      post_cnt  <= '0;
    end else if (restart) begin
      st        <= ARMED;
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      post_cnt  <= '0;
    end else begin
      case (st)
        ARMED: begin
          if (ret_valid) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (count != FULL) count <= count + (ADDR_W+1)'(1);
            if (hit) begin
              triggered <= 1'b1;
              if (POST_TRIG == 0) begin
                st <= DONE;
              end else begin
                st       <= POST;
                post_cnt <= POST_N;
              end
            end
          end
        end
        POST: begin
          if (ret_valid) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            if (count != FULL) count <= count + (ADDR_W+1)'(1);
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) st <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // trace storage: single shared port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we)    mem[port_addr] <= entry;
    if (rd_go) mem_q <= mem[port_addr];
  end

  // read handshake: one-cycle latency, out-of-range indices return zero data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      rd_zero  <= rd_oob;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - scoreboard bench for trace_buffer (POST_TRIG=0 and POST_TRIG=16 instances)
module tb_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = 60;
`else
  localparam int DW = 44;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b1;
  logic [15:0] trig_pc = 16'h0;
  logic        ret_valid = 1'b0;
  logic [15:0] ret_pc = 16'h0;
  logic [7:0]  ret_ir = 8'h0;
  logic [15:0] ret_sp = 16'h0;
  logic [3:0]  ret_flags = 4'h0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_idx = 6'd0;

  logic          rv0, rv1, tr0, tr1;
  logic [DW-1:0] rd0, rd1;
  logic [1:0]    st0, st1;
  logic [6:0]    cnt0, cnt1;

  trace_buffer #(.DEPTH(64), .POST_TRIG(0)) u0 (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir), .ret_sp(ret_sp),
    .ret_flags(ret_flags), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rv0),
    .rd_data(rd0), .state(st0), .count(cnt0), .triggered(tr0));

  trace_buffer #(.DEPTH(64), .POST_TRIG(16)) u16 (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir), .ret_sp(ret_sp),
    .ret_flags(ret_flags), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rv1),
    .rd_data(rd1), .state(st1), .count(cnt1), .triggered(tr1));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [43:0] d;
    int          due;
  } exp_t;

  exp_t        sb [2][$];
  logic [15:0] ts_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus encoding: every field derived from the PC so one value identifies the entry
  function automatic logic [43:0] ent(input logic [15:0] pc);
    logic [7:0] ir;
    logic [15:0] sp;
    ir = pc[7:0] ^ 8'h5A;
    sp = 16'hFFFE - pc;
    return {pc, ir, sp, pc[3:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic retire(input logic [15:0] pc);
    logic [43:0] e;
    e = ent(pc);
    ret_valid = 1'b1;
    ret_pc    = e[43:28];
    ret_ir    = e[27:20];
    ret_sp    = e[19:4];
    ret_flags = e[3:0];
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Issue one read; push an expectation for each instance that should answer
  task automatic rd(input int idx, input bit e0, input logic [43:0] d0,
                    input bit e1, input logic [43:0] d1);
    exp_t x;
    rd_req = 1'b1;
    rd_idx = 6'(idx);
    if (e0) begin x.d = d0; x.due = cyc + 1; sb[0].push_back(x); end
    if (e1) begin x.d = d1; x.due = cyc + 1; sb[1].push_back(x); end
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever an instance presents rd_valid
  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        logic          v;
        logic [DW-1:0] d;
        exp_t          x;
        v = (u == 0) ? rv0 : rv1;
        d = (u == 0) ? rd0 : rd1;
        while (sb[u].size() > 0 && sb[u][0].due < cyc) begin
          checks++;
          fails++;
          $display("FAIL u%0d_missing_rd_valid: got 0 expected 1", u);
          void'(sb[u].pop_front());
        end
        if (v) begin
          if (sb[u].size() == 0 || sb[u][0].due != cyc) begin
            checks++;
            fails++;
            $display("FAIL u%0d_unexpected_rd_valid: got 1 expected 0", u);
          end else begin
            x = sb[u].pop_front();
            chk($sformatf("u%0d_rd_data", u), 64'(d[DW-1:DW-44]), 64'(x.d));
`ifdef TRACE_TIMESTAMP_EN
            if (u == 0) ts_q.push_back(d[15:0]);
`endif
          end
        end
      end
    end
  end

  initial begin
    // reset held with retire strobe toggling
    for (int i = 0; i < 3; i++) begin
      ret_valid = ~ret_valid;
      ret_pc    = 16'h0109;
      tick();
      chk("rst_state", 64'(st0), 64'd0);
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_rd_valid", 64'(rv0), 64'd0);
    end
    ret_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_triggered", 64'(tr0), 64'd0);
    chk("rst_rd_data", 64'(rd0), 64'd0);

    // read outside DONE is not answered
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("idle_rd_valid", 64'(rv0), 64'd0);

    // no-wrap capture: trigger on the 10th retire
    trig_pc = 16'h0109;
    do_arm();
    chk("armed_state", 64'(st0), 64'd1);
    for (int i = 0; i < 10; i++) retire(16'h0100 + 16'(i));
    chk("nowrap_state_u0", 64'(st0), 64'd3);
    chk("nowrap_count_u0", 64'(cnt0), 64'd10);
    chk("nowrap_trig_u0", 64'(tr0), 64'd1);
    chk("nowrap_state_u16", 64'(st1), 64'd2);
    rd(0, 1, ent(16'h0100), 0, '0);
    rd(9, 1, ent(16'h0109), 0, '0);
    rd(20, 1, 44'h0, 0, '0);
    chk("post_rd_valid_u16", 64'(rv1), 64'd0);

    // finish the POST_TRIG=16 window; u0 is DONE and must not record these
    for (int i = 0; i < 16; i++) begin
      retire(16'h0200 + 16'(i));
      if (i == 14) chk("post_hold_u16", 64'(st1), 64'd2);
    end
    chk("post_done_u16", 64'(st1), 64'd3);
    chk("post_count_u16", 64'(cnt1), 64'd26);
    chk("done_count_u0", 64'(cnt0), 64'd10);
    rd(0, 1, ent(16'h0100), 1, ent(16'h0100));
    rd(25, 1, 44'h0, 1, ent(16'h020F));
    rd(10, 1, 44'h0, 1, ent(16'h0200));

    // wrap capture: 100 retires, trigger at 0x0050
    trig_pc = 16'h0050;
    do_arm();
    for (int i = 0; i < 100; i++) begin
      retire(16'(i));
      if (i == 16'h50) begin
        chk("wrap_trig_state_u0", 64'(st0), 64'd3);
        chk("wrap_trig_state_u16", 64'(st1), 64'd2);
      end
    end
    chk("wrap_state_u16", 64'(st1), 64'd3);
    chk("wrap_count_u16", 64'(cnt1), 64'd64);
    chk("wrap_count_u0", 64'(cnt0), 64'd64);
    rd(0, 1, ent(16'h0011), 1, ent(16'h0021));
    rd(63, 1, ent(16'h0050), 1, ent(16'h0060));
    rd(1, 1, ent(16'h0012), 1, ent(16'h0022));

    // arm coinciding with a matching retire: arm wins, nothing recorded
    do_arm();
    retire(16'h0030);
    retire(16'h0031);
    chk("rearm_count", 64'(cnt1), 64'd2);
    arm = 1'b1;
    retire(16'h0050);
    arm = 1'b0;
    chk("simul_state_u0", 64'(st0), 64'd1);
    chk("simul_state_u16", 64'(st1), 64'd1);
    chk("simul_count_u0", 64'(cnt0), 64'd0);
    chk("simul_trig_u0", 64'(tr0), 64'd0);
    chk("simul_trig_u16", 64'(tr1), 64'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("armed_rd_valid", 64'(rv0), 64'd0);

    // asynchronous reset in the middle of a capture
    retire(16'h0001);
    retire(16'h0002);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state", 64'(st0), 64'd0);
    chk("midrst_count", 64'(cnt0), 64'd0);
    tick();
    rst = 1'b1;
    tick();

`ifdef TRACE_TIMESTAMP_EN
    // two retires four cycles apart: stamps differ by 4
    trig_pc = 16'h0777;
    do_arm();
    retire(16'h0700);
    tick();
    tick();
    tick();
    retire(16'h0777);
    chk("ts_done", 64'(st0), 64'd3);
    rd(0, 1, ent(16'h0700), 0, '0);
    rd(1, 1, ent(16'h0777), 0, '0);
    tick();
    tick();
    if (ts_q.size() == 2) chk("ts_delta", 64'(ts_q[1] - ts_q[0]), 64'd4);
    else chk("ts_samples", 64'(ts_q.size()), 64'd2);
`endif

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (sb[0].size() + sb[1].size()) > 0; i++) tick();
    chk("sb_drained_u0", 64'(sb[0].size()), 64'd0);
    chk("sb_drained_u16", 64'(sb[1].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
